// File: rtl/can_tx_pkg.sv
// Shared types and constants for the CAN transmit path.
// Holds the loader state encoding and frame field bounds.
package can_tx_pkg;

    localparam int CAN_MSG_W  = 128;
    localparam int CAN_ID_MSB = 127;
    localparam int CAN_ID_LSB = 96;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        ACTIVE  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/can_tx_retry_counter.sv
// Per-frame retry counter: clear, saturating increment, limit flag.
// Ports: clk/rst_n, clr, inc in; cnt, at_limit out (MAX_RETRIES 0 = no limit).
module can_tx_retry_counter
    import can_tx_pkg::*;
#(
    parameter int unsigned MAX_RETRIES = 0,
    parameter int          RETRY_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [RETRY_W-1:0] cnt,
    output logic               at_limit
);

    localparam logic [RETRY_W-1:0] LIMIT = RETRY_W'(MAX_RETRIES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + RETRY_W'(1);
        end
    end

    assign at_limit = (MAX_RETRIES != 0) && (cnt == LIMIT);

endmodule

// File: rtl/can_tx_msg_loader.sv
// CAN TX message loader: fetches frames from TXHPB/FIFO, presents, retries.
// Ports: source read strobes/data in, frame + valid out, BSP events in, status pulses out.
module can_tx_msg_loader
    import can_tx_pkg::*;
#(
    parameter int unsigned MAX_RETRIES = 0,
    parameter int          RETRY_W     = 8
) (
    input  logic                 i_sys_clk,
    input  logic                 i_reset_n,
    input  logic                 i_en,
    input  logic                 i_abort,
    input  logic                 i_txhpb_full,
    output logic                 o_txhpb_r_en,
    input  logic [CAN_MSG_W-1:0] i_txhpb_r_data,
    input  logic                 i_tx_fifo_empty,
    output logic                 o_tx_fifo_r_en,
    input  logic [CAN_MSG_W-1:0] i_tx_fifo_r_data,
    output logic                 o_tx_valid,
    output logic [CAN_MSG_W-1:0] o_tx_message,
    input  logic                 i_tx_start,
    input  logic                 i_tx_done,
    input  logic                 i_tx_arb_lost,
    input  logic                 i_tx_error,
    output logic                 o_txok,
    output logic                 o_arbl,
    output logic                 o_tx_drop,
    output logic                 o_busy,
    output logic                 o_src_hpb,
    output logic [RETRY_W-1:0]   o_retry_cnt
);

    tx_state_t state;
    logic      idle_en;
    logic      rd_any;
    logic      ev_fail;
    logic      give_up;
    logic      at_limit;

    // Strobes are gated by reset so every output reads 0 while it is held.
    assign idle_en        = i_reset_n && (state == IDLE) && i_en;
    assign o_txhpb_r_en   = idle_en && i_txhpb_full;
    assign o_tx_fifo_r_en = idle_en && !i_txhpb_full
                            && !i_tx_fifo_empty;
    assign rd_any         = o_txhpb_r_en || o_tx_fifo_r_en;

    // Done outranks error/arb_lost when they coincide.
    assign ev_fail = (state == ACTIVE) && !i_tx_done
                     && (i_tx_error || i_tx_arb_lost);
    assign give_up = i_abort || at_limit;
    assign o_busy  = (state != IDLE);

    can_tx_retry_counter #(
        .MAX_RETRIES (MAX_RETRIES),
        .RETRY_W     (RETRY_W)
    ) u_retry (
        .clk      (i_sys_clk),
        .rst_n    (i_reset_n),
        .clr      (rd_any),
        .inc      (ev_fail && !give_up),
        .cnt      (o_retry_cnt),
        .at_limit (at_limit)
    );

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= IDLE;
            o_tx_valid   <= 1'b0;
            o_tx_message <= '0;
            o_txok       <= 1'b0;
            o_arbl       <= 1'b0;
            o_tx_drop    <= 1'b0;
            o_src_hpb    <= 1'b0;
        end else begin
            o_txok    <= 1'b0;
            o_arbl    <= 1'b0;
            o_tx_drop <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rd_any) begin
                        o_src_hpb <= o_txhpb_r_en;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    o_tx_message <= o_src_hpb ? i_txhpb_r_data
                                              : i_tx_fifo_r_data;
                    o_tx_valid   <= 1'b1;
                    state        <= PRESENT;
                end
                PRESENT: begin
                    if (i_abort) begin
                        o_tx_drop  <= 1'b1;
                        o_tx_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (i_tx_start) begin
                        o_tx_valid <= 1'b0;
                        state      <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    o_arbl <= i_tx_arb_lost;
                    if (i_tx_done) begin
                        o_txok <= 1'b1;
                        state  <= IDLE;
                    end else if (ev_fail && give_up) begin
                        o_tx_drop <= 1'b1;
                        state     <= IDLE;
                    end else if (ev_fail) begin
                        o_tx_valid <= 1'b1;
                        state      <= PRESENT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_can_tx_msg_loader.sv
// Bench for can_tx_msg_loader: vector table, scoreboard, corner sequences.
// Two instances: unlimited retries (dut) and MAX_RETRIES=2 (dut2).
module tb_can_tx_msg_loader;

    localparam int RW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en, abort;
    logic           hpb_full, fifo_empty;
    logic [127:0]   hpb_data, fifo_data;
    logic           start, done, arb, err;

    logic           hpb_r, fifo_r, valid, txok, arbl, drop, busy, src;
    logic [127:0]   msg;
    logic [RW-1:0]  cnt;

    logic           hpb_r2, fifo_r2, valid2, txok2, arbl2, drop2;
    logic           busy2, src2;
    logic [127:0]   msg2;
    logic [RW-1:0]  cnt2;

    int errs = 0;
    int checks = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    can_tx_msg_loader #(.MAX_RETRIES(0), .RETRY_W(RW)) dut (
        .i_sys_clk(clk), .i_reset_n(rst_n), .i_en(en),
        .i_abort(abort), .i_txhpb_full(hpb_full),
        .o_txhpb_r_en(hpb_r), .i_txhpb_r_data(hpb_data),
        .i_tx_fifo_empty(fifo_empty), .o_tx_fifo_r_en(fifo_r),
        .i_tx_fifo_r_data(fifo_data), .o_tx_valid(valid),
        .o_tx_message(msg), .i_tx_start(start),
        .i_tx_done(done), .i_tx_arb_lost(arb),
        .i_tx_error(err), .o_txok(txok), .o_arbl(arbl),
        .o_tx_drop(drop), .o_busy(busy), .o_src_hpb(src),
        .o_retry_cnt(cnt)
    );

    can_tx_msg_loader #(.MAX_RETRIES(2), .RETRY_W(RW)) dut2 (
        .i_sys_clk(clk), .i_reset_n(rst_n), .i_en(en),
        .i_abort(abort), .i_txhpb_full(hpb_full),
        .o_txhpb_r_en(hpb_r2), .i_txhpb_r_data(hpb_data),
        .i_tx_fifo_empty(fifo_empty), .o_tx_fifo_r_en(fifo_r2),
        .i_tx_fifo_r_data(fifo_data), .o_tx_valid(valid2),
        .o_tx_message(msg2), .i_tx_start(start),
        .i_tx_done(done), .i_tx_arb_lost(arb),
        .i_tx_error(err), .o_txok(txok2), .o_arbl(arbl2),
        .o_tx_drop(drop2), .o_busy(busy2), .o_src_hpb(src2),
        .o_retry_cnt(cnt2)
    );

    task automatic chk1(input string nm, input logic got,
                        input logic exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b want %b", nm, got, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [127:0] got,
                        input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [RW-1:0] got,
                        input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    // Next cycle: pulse inputs drop back to 0 at each falling edge.
    task automatic cyc();
        @(negedge clk);
        start = 1'b0;
        done  = 1'b0;
        arb   = 1'b0;
        err   = 1'b0;
    endtask

    // From IDLE, fetch one FIFO frame; returns in the first PRESENT cycle.
    task automatic fetch_fifo(input logic [127:0] w);
        cyc();
        fifo_data  = w;
        fifo_empty = 1'b0;
        exp_q.push_back(w);
        #1;
        chk1("fifo_r_en", fifo_r, 1'b1);
        chk1("hpb_r_en_off", hpb_r, 1'b0);
        cyc();
        fifo_empty = 1'b1;
        #1;
        chk1("fetch_no_strobe", fifo_r, 1'b0);
        chk1("fetch_valid", valid, 1'b0);
        chk1("fetch_busy", busy, 1'b1);
        cyc();
        #1;
        chk1("present_valid", valid, 1'b1);
    endtask

    // From a PRESENT cycle: start then done, expect txok.
    task automatic finish_ok();
        start = 1'b1;
        cyc();
        #1;
        chk1("active_valid", valid, 1'b0);
        done = 1'b1;
        cyc();
        #1;
        chk1("txok", txok, 1'b1);
        chk1("idle_busy", busy, 1'b0);
        chk1("no_drop", drop, 1'b0);
    endtask

    // Scoreboard: every rising o_tx_valid must show the head frame;
    // the head retires on txok or drop.
    initial begin
        logic pv;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                pv = 1'b0;
            end else begin
                if (valid && !pv) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL sb_empty: got %h want none",
                                 msg);
                    end else begin
                        chkw("sb_msg", msg, exp_q[0]);
                    end
                end
                if (txok || drop) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL sb_retire: got pulse want none");
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
                pv = valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic en;
        logic hpb;
        logic fifo;
        logic e_hpb;
        logic e_fifo;
        logic e_src;
    } vec_t;

    vec_t tbl [5];
    logic [127:0] w;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0; en = 1'b0; abort = 1'b0;
        hpb_full = 1'b0; fifo_empty = 1'b1;
        hpb_data = '0; fifo_data = '0;
        start = 1'b0; done = 1'b0; arb = 1'b0; err = 1'b0;
        #3;
        chk1("rst_valid", valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chkw("rst_msg", msg, 128'h0);
        chk8("rst_cnt", cnt, 8'd0);
        #9;
        rst_n = 1'b1;

        // FIFO path
        cyc();
        en = 1'b1;
        fetch_fifo(128'hA55A_0000_1111_2222_3333_4444_5555_6601);
        chk1("fifo_src", src, 1'b0);
        finish_ok();

        // Source selection table
        for (int i = 0; i < 5; i++) begin
            cyc();
            en         = tbl[i].en;
            hpb_full   = tbl[i].hpb;
            fifo_empty = !tbl[i].fifo;
            hpb_data   = {96'hB0B0_0000_0000, 32'(i)};
            fifo_data  = {96'hC0C0_0000_0000, 32'(i)};
            #1;
            chk1("tbl_hpb_r", hpb_r, tbl[i].e_hpb);
            chk1("tbl_fifo_r", fifo_r, tbl[i].e_fifo);
            if (tbl[i].e_hpb || tbl[i].e_fifo) begin
                exp_q.push_back(tbl[i].e_hpb ? hpb_data
                                             : fifo_data);
                cyc();
                hpb_full   = 1'b0;
                fifo_empty = 1'b1;
                cyc();
                #1;
                chk1("tbl_valid", valid, 1'b1);
                chk1("tbl_src", src, tbl[i].e_src);
                finish_ok();
            end else begin
                cyc();
                hpb_full   = 1'b0;
                fifo_empty = 1'b1;
                #1;
                chk1("tbl_stay_idle", busy, 1'b0);
            end
        end
        en = 1'b1;

        // Priority, then the waiting FIFO frame follows
        cyc();
        hpb_data   = 128'hD00D_1234;
        fifo_data  = 128'hF1F0_5678;
        hpb_full   = 1'b1;
        fifo_empty = 1'b0;
        exp_q.push_back(hpb_data);
        exp_q.push_back(fifo_data);
        #1;
        chk1("pri_hpb_r", hpb_r, 1'b1);
        chk1("pri_fifo_r", fifo_r, 1'b0);
        cyc();
        hpb_full = 1'b0;
        #1;
        chk1("pri_fetch_fifo_r", fifo_r, 1'b0);
        cyc();
        #1;
        chk1("pri_src", src, 1'b1);
        start = 1'b1;
        cyc();
        #1;
        done = 1'b1;
        cyc();
        #1;
        chk1("pri_txok", txok, 1'b1);
        chk1("pri_next_fifo_r", fifo_r, 1'b1);
        cyc();
        fifo_empty = 1'b1;
        cyc();
        #1;
        chk1("pri2_valid", valid, 1'b1);
        chk1("pri2_src", src, 1'b0);
        finish_ok();

        // Three arbitration losses
        fetch_fifo(128'h1111_2222_3333_4444_5555_6666_7777_8888);
        for (int k = 1; k <= 3; k++) begin
            start = 1'b1;
            cyc();
            #1;
            chk1("arb_active_valid", valid, 1'b0);
            arb = 1'b1;
            cyc();
            #1;
            chk1("arbl", arbl, 1'b1);
            chk1("arb_re_valid", valid, 1'b1);
            chk8("arb_cnt", cnt, RW'(k));
            chk1("lim_drop", drop2, (k == 3));
            chk1("lim_valid", valid2, (k != 3));
        end
        finish_ok();
        chk8("arb_cnt_hold", cnt, 8'd3);

        // Three bus errors: dut2 gives up, dut is then aborted
        fetch_fifo(128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001);
        for (int k = 1; k <= 3; k++) begin
            start = 1'b1;
            cyc();
            err = 1'b1;
            cyc();
            #1;
            chk1("err_arbl", arbl, 1'b0);
            chk1("err_re_valid", valid, 1'b1);
            chk8("err_cnt", cnt, RW'(k));
            chk1("errlim_drop", drop2, (k == 3));
            chk1("errlim_valid", valid2, (k != 3));
            chk1("errlim_busy", busy2, (k != 3));
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        #1;
        chk1("abort_present_drop", drop, 1'b1);
        chk1("abort_present_valid", valid, 1'b0);
        chk1("abort_present_busy", busy, 1'b0);

        // Abort while active does not cancel a successful frame
        fetch_fifo(128'h0BAD_F00D);
        start = 1'b1;
        cyc();
        abort = 1'b1;
        cyc();
        done = 1'b1;
        cyc();
        abort = 1'b0;
        #1;
        chk1("abort_act_txok", txok, 1'b1);
        chk1("abort_act_drop", drop, 1'b0);
        cyc();
        #1;
        chkw("sb_drained", 128'(exp_q.size()), 128'h0);

        // Asynchronous reset while active, sources still full
        cyc();
        hpb_data   = 128'hFEED_0000_0000_0000_0000_0000_0000_BEEF;
        hpb_full   = 1'b1;
        fifo_empty = 1'b0;
        exp_q.push_back(hpb_data);
        cyc();
        cyc();
        #1;
        start = 1'b1;
        cyc();
        #1;
        chk1("rst_pre_busy", busy, 1'b1);
        chk1("rst_pre_src", src, 1'b1);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        exp_q.delete();
        #1;
        chk1("arst_valid", valid, 1'b0);
        chk1("arst_hpb_r", hpb_r, 1'b0);
        chk1("arst_fifo_r", fifo_r, 1'b0);
        chk1("arst_txok", txok, 1'b0);
        chk1("arst_arbl", arbl, 1'b0);
        chk1("arst_drop", drop, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_src", src, 1'b0);
        chkw("arst_msg", msg, 128'h0);
        chk8("arst_cnt", cnt, 8'd0);
        cyc();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            chk1("post_rst_hpb_r", hpb_r, 1'b0);
            chk1("post_rst_fifo_r", fifo_r, 1'b0);
            chk1("post_rst_busy", busy, 1'b0);
        end
        hpb_full   = 1'b0;
        fifo_empty = 1'b1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/can_tx_msg_loader.md
# can_tx_msg_loader

Transmit-side message loader for the CAN controller. It pulls 128-bit frames from the TX high-priority buffer (TXHPB) or the TX FIFO, presents them to the bit stream processor, and retries the frame on arbitration loss or bus error. It reports per-frame status back to the configuration register block. It is the transmit counterpart of the receive acceptance filter path.

## Interface
- `MAX_RETRIES`, default 0: retry limit per frame; 0 means unlimited, which is standard CAN automatic retransmission.
- `RETRY_W`, default 8: width of the retry counter.
- `i_sys_clk` in 1: system clock; the only clock.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_en` in 1: core enable from the configuration registers.
- `i_abort` in 1: level; cancel the pending frame.
- `i_txhpb_full` in 1: TXHPB holds a frame.
- `o_txhpb_r_en` out 1: TXHPB read strobe.
- `i_txhpb_r_data` in 128: TXHPB read data, valid the cycle after `o_txhpb_r_en`.
- `i_tx_fifo_empty` in 1: TX FIFO is empty.
- `o_tx_fifo_r_en` out 1: TX FIFO read strobe.
- `i_tx_fifo_r_data` in 128: TX FIFO read data, valid the cycle after `o_tx_fifo_r_en`.
- `o_tx_valid` out 1: frame is presented to the bit stream processor.
- `o_tx_message` out 128: frame; ID field is [127:96].
- `i_tx_start` in 1: pulse; the bit stream processor took the frame (SOF sent). Already synchronized to `i_sys_clk`.
- `i_tx_done` in 1: pulse; frame sent successfully.
- `i_tx_arb_lost` in 1: pulse; arbitration lost.
- `i_tx_error` in 1: pulse; bus error during transmission.
- `o_txok` out 1: one-cycle pulse on success.
- `o_arbl` out 1: one-cycle pulse, echoes each `i_tx_arb_lost` seen while in ACTIVE.
- `o_tx_drop` out 1: one-cycle pulse when a frame is discarded.
- `o_busy` out 1: high in any state other than IDLE.
- `o_src_hpb` out 1: the current frame came from TXHPB.
- `o_retry_cnt` out RETRY_W: retries for the current frame.

## Operation
- States: IDLE, FETCH, PRESENT, ACTIVE.
- **IDLE**
  - `i_en` low: remain in IDLE, no reads.
  - Otherwise, if `i_txhpb_full`: assert `o_txhpb_r_en`, set `o_src_hpb`=1, go to FETCH.
  - Otherwise, if `!i_tx_fifo_empty`: assert `o_tx_fifo_r_en`, set `o_src_hpb`=0, go to FETCH.
  - TXHPB always wins when both sources have a frame.
  - Entering FETCH clears `o_retry_cnt`.
- **FETCH**: capture the selected read data into the message register, then go to PRESENT.
- **PRESENT**: `o_tx_valid`=1.
  - `i_abort`: pulse `o_tx_drop`, go to IDLE.
  - Otherwise `i_tx_start`: go to ACTIVE.
  - Abort wins if both occur in the same cycle.
- **ACTIVE**: `o_tx_valid`=0. Event priority is `i_tx_done` > `i_tx_error` > `i_tx_arb_lost`.
  - done: pulse `o_txok`, go to IDLE.
  - error or arb_lost, with `i_abort` high, or `MAX_RETRIES`≠0 and `o_retry_cnt`==`MAX_RETRIES`: pulse `o_tx_drop`, go to IDLE.
  - error or arb_lost otherwise: increment `o_retry_cnt` (saturating at all-ones), go to PRESENT with the same message.
- No preemption: a frame already fetched is never displaced by a later TXHPB frame.
- `i_en` falling does not affect a frame in flight. The block finishes that frame and then idles.
- `i_start`, `i_done`, `i_arb_lost` and `i_error` pulses arriving in IDLE or FETCH are ignored.

## Timing
- Read strobes are combinational from IDLE state and inputs, and last exactly one cycle.
- The source is sampled in cycle N. Data is captured at the end of cycle N+1. `o_tx_valid` rises in cycle N+2.
- Retry: an error pulse in cycle M drives `o_tx_valid` high again in cycle M+1.
- A status pulse occurs in the cycle after the triggering input. The next read can be issued in that same cycle, since state is IDLE.
- Reset values:
  - state IDLE
  - `o_tx_valid`, `o_txhpb_r_en`, `o_tx_fifo_r_en`, `o_txok`, `o_arbl`, `o_tx_drop`, `o_busy`, `o_src_hpb` = 0
  - `o_tx_message` = 0
  - `o_retry_cnt` = 0
- Reset asserted mid-frame: the frame is lost with no drop pulse, and nothing is re-read.

## Structure
- Package `can_tx_pkg` holds:
  - the state enum `tx_state_t`
  - `CAN_MSG_W`=128
  - ID field bounds `CAN_ID_MSB`=127 and `CAN_ID_LSB`=96
- Sub-module `can_tx_retry_counter` provides:
  - a clear/increment saturating counter
  - a limit-reached compare against `MAX_RETRIES`, with 0 meaning unlimited
- Everything else lives in the single FSM module.

## Test plan
- **FIFO path:** FIFO non-empty with data `128'hA5..01`, TXHPB empty.
  - Expect `o_tx_fifo_r_en` for one cycle, `o_tx_valid` two cycles later with `o_tx_message`=`128'hA5..01`.
  - Then `i_tx_start` followed by `i_tx_done` gives an `o_txok` pulse and IDLE.
- **Priority:** TXHPB full and FIFO non-empty in the same cycle.
  - Expect `o_txhpb_r_en` only and `o_src_hpb`=1.
  - After done, the FIFO frame is fetched next.
- **Unlimited retries:** `MAX_RETRIES`=0, three `i_tx_arb_lost` pulses.
  - Expect three `o_arbl` pulses, `o_retry_cnt`=3, and the same message re-presented each time.
  - Then done gives `o_txok`.
- **Retry limit:** `MAX_RETRIES`=2, three `i_tx_error` pulses.
  - Expect the third error to give `o_tx_drop` with no re-present and IDLE.
- **Abort:**
  - `i_abort` in PRESENT: `o_tx_drop` next cycle, `o_tx_valid`=0.
  - `i_abort` in ACTIVE followed by done: `o_txok`, not `o_tx_drop`.
- **Reset in ACTIVE:** drive `i_reset_n` low asynchronously.
  - All outputs read 0 immediately.
  - After release with `i_en`=0, no read strobes are issued.
